// File: rtl/frame_sched_if.sv
// frame_sched_if: bundle between the frame sequencer, the per-object
// updaters and the framebuffer write port.
//   start      per-slot start, one-hot or zero
//   done       per-slot done from the updaters
//   obj_x      slot i x in bits [8i+7:8i]
//   obj_y      slot i y in bits [7i+6:7i]
//   obj_color  slot i colour in bits [3i+2:3i]
//   obj_wren   per-slot plot request
//   vga_*      framebuffer x/y/colour and write strobe
//   busy       sequencer not idle
//   fault      sticky per-slot timeout flags
//   overrun    sticky, a frame tick arrived while busy
// master = sequencer side, slave = updater/framebuffer side.
interface frame_sched_if #(
   parameter int N_OBJ = 4
);
   logic [N_OBJ-1:0]   start;
   logic [N_OBJ-1:0]   done;
   logic [8*N_OBJ-1:0] obj_x;
   logic [7*N_OBJ-1:0] obj_y;
   logic [3*N_OBJ-1:0] obj_color;
   logic [N_OBJ-1:0]   obj_wren;
   logic [7:0]         vga_x;
   logic [6:0]         vga_y;
   logic [2:0]         vga_color;
   logic               vga_plot;
   logic               busy;
   logic [N_OBJ-1:0]   fault;
   logic               overrun;

   modport master (
      output start, vga_x, vga_y, vga_color, vga_plot, busy, fault, overrun,
      input  done, obj_x, obj_y, obj_color, obj_wren
   );

   modport slave (
      input  start, vga_x, vga_y, vga_color, vga_plot, busy, fault, overrun,
      output done, obj_x, obj_y, obj_color, obj_wren
   );
endinterface

// File: rtl/frame_sched.sv
// frame_sched: once per frame, optionally erases every object's previously
// drawn pixel, then runs each object slot through a start/done handshake,
// forwarding the active slot's plot requests to the single framebuffer port.
// Slot timeouts set a sticky fault bit; a frame tick while busy sets overrun.
//
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous, active-high
//   bus    frame_sched_if.master (handshake, object inputs, vga outputs,
//          busy/fault/overrun status)
//
// Build option: define FRAME_SCHED_ERASE_EN to add the ERASE phase and the
// per-slot last-position registers. Without it IDLE goes straight to START.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for the frame tick
// ERASE   | one cycle per slot, re-plot last position in colour 0
// START   | start[idx] asserted, timeout counter loaded
// WAIT    | start[idx] held, plots forwarded, waiting for done[idx]
// RELEASE | start[idx] dropped, waiting for done[idx] to fall
module frame_sched #(
   parameter int N_OBJ     = 4,
   parameter int FRAME_DIV = 833333,
   parameter int TIMEOUT   = 64
) (
   input logic           clk,
   input logic           reset,
   frame_sched_if.master bus
);
   localparam int IDX_W = (N_OBJ > 1) ? $clog2(N_OBJ) : 1;
   localparam int CNT_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
   localparam int TMR_W = $clog2(TIMEOUT + 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_OBJ - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(FRAME_DIV - 1);
   localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT);
   localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ERASE   = 3'd1,
      S_START   = 3'd2,
      S_WAIT    = 3'd3,
      S_RELEASE = 3'd4
   } state_t;

   state_t           state, state_nxt;
   logic [IDX_W-1:0] idx, idx_nxt;
   logic [TMR_W-1:0] tmr, tmr_nxt;
   logic [CNT_W-1:0] frame_cnt;
   logic             tick;
   logic             slot_end;
   logic             timeout;

   logic [N_OBJ-1:0] start;
   logic             plot;
   logic [7:0]       px;
   logic [6:0]       py;
   logic [2:0]       pc;
   logic [7:0]       hold_x;
   logic [6:0]       hold_y;
   logic [2:0]       hold_c;
   logic [N_OBJ-1:0] fault_q;
   logic             overrun_q;

   logic [7:0] ox [N_OBJ];
   logic [6:0] oy [N_OBJ];
   logic [2:0] oc [N_OBJ];

   always_comb begin
      for (int i = 0; i < N_OBJ; i++) begin
         ox[i] = bus.obj_x[8*i +: 8];
         oy[i] = bus.obj_y[7*i +: 7];
         oc[i] = bus.obj_color[3*i +: 3];
      end
   end

   // free-running frame counter, never stalled by the sequencer
   assign tick = (frame_cnt == CNT_MAX);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)     frame_cnt <= '0;
      else if (tick) frame_cnt <= '0;
      else           frame_cnt <= frame_cnt + 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= S_IDLE;
         idx   <= '0;
         tmr   <= '0;
      end else begin
         state <= state_nxt;
         idx   <= idx_nxt;
         tmr   <= tmr_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      tmr_nxt   = tmr;
      slot_end  = 1'b0;
      timeout   = 1'b0;
      case (state)
         S_IDLE: begin
            if (tick) begin
               idx_nxt = '0;
`ifdef FRAME_SCHED_ERASE_EN
               state_nxt = S_ERASE;
`else
               state_nxt = S_START;
`endif
            end
         end
         S_ERASE: begin
            if (idx == LAST_IDX) begin
               idx_nxt   = '0;
               state_nxt = S_START;
            end else begin
               idx_nxt = idx + 1'b1;
            end
         end
         S_START: begin
            tmr_nxt   = TMR_LOAD;
            state_nxt = S_WAIT;
         end
         S_WAIT: begin
            // done wins over a timeout landing on the same cycle
            if (bus.done[idx]) begin
               tmr_nxt   = TMR_LOAD;
               state_nxt = S_RELEASE;
            end else if (tmr <= TMR_ONE) begin
               timeout  = 1'b1;
               slot_end = 1'b1;
            end else begin
               tmr_nxt = tmr - 1'b1;
            end
         end
         S_RELEASE: begin
            if (!bus.done[idx]) begin
               slot_end = 1'b1;
            end else if (tmr <= TMR_ONE) begin
               timeout  = 1'b1;
               slot_end = 1'b1;
            end else begin
               tmr_nxt = tmr - 1'b1;
            end
         end
         default: state_nxt = S_IDLE;
      endcase

      if (slot_end) begin
         if (idx == LAST_IDX) begin
            idx_nxt   = '0;
            state_nxt = S_IDLE;
         end else begin
            idx_nxt   = idx + 1'b1;
            state_nxt = S_START;
         end
      end
   end

`ifdef FRAME_SCHED_ERASE_EN
   logic [7:0]       last_x [N_OBJ];
   logic [6:0]       last_y [N_OBJ];
   logic [N_OBJ-1:0] last_valid;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_valid <= '0;
         for (int i = 0; i < N_OBJ; i++) begin
            last_x[i] <= '0;
            last_y[i] <= '0;
         end
      end else if (state == S_ERASE) begin
         last_valid[idx] <= 1'b0;
      end else if (state == S_WAIT && bus.obj_wren[idx]) begin
         last_x[idx]     <= ox[idx];
         last_y[idx]     <= oy[idx];
         last_valid[idx] <= 1'b1;
      end
   end
`endif

   // vga_* fall back to the held values whenever nothing is plotted
   always_comb begin
      start = '0;
      plot  = 1'b0;
      px    = hold_x;
      py    = hold_y;
      pc    = hold_c;
      case (state)
`ifdef FRAME_SCHED_ERASE_EN
         S_ERASE: begin
            if (last_valid[idx]) begin
               plot = 1'b1;
               px   = last_x[idx];
               py   = last_y[idx];
               pc   = '0;
            end
         end
`endif
         S_START: start[idx] = 1'b1;
         S_WAIT: begin
            start[idx] = 1'b1;
            if (bus.obj_wren[idx]) begin
               plot = 1'b1;
               px   = ox[idx];
               py   = oy[idx];
               pc   = oc[idx];
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hold_x    <= '0;
         hold_y    <= '0;
         hold_c    <= '0;
         fault_q   <= '0;
         overrun_q <= 1'b0;
      end else begin
         if (plot) begin
            hold_x <= px;
            hold_y <= py;
            hold_c <= pc;
         end
         if (timeout)
            fault_q[idx] <= 1'b1;
         if (tick && state != S_IDLE)
            overrun_q <= 1'b1;
      end
   end

   assign bus.start     = start;
   assign bus.vga_plot  = plot;
   assign bus.vga_x     = px;
   assign bus.vga_y     = py;
   assign bus.vga_color = pc;
   assign bus.busy      = (state != S_IDLE);
   assign bus.fault     = fault_q;
   assign bus.overrun   = overrun_q;
endmodule

// File: tb/tb_frame_sched.sv
// Bench for frame_sched: N_OBJ=2, FRAME_DIV=16, TIMEOUT=8. Per-frame slot
// behaviour (done delay, done hold, plot requests) is drawn at random, and
// the expected cycle-by-cycle outputs are laid out on a timeline computed
// from the frame/slot rules with plain arithmetic.
module tb_frame_sched;
   localparam int N_OBJ     = 2;
   localparam int FRAME_DIV = 16;
   localparam int TIMEOUT   = 8;
   localparam int MAXC      = 1000;
   localparam int XW        = 8 * N_OBJ;
   localparam int YW        = 7 * N_OBJ;
   localparam int CW        = 3 * N_OBJ;
`ifdef FRAME_SCHED_ERASE_EN
   localparam bit ERASE = 1'b1;
`else
   localparam bit ERASE = 1'b0;
`endif

   logic clk   = 1'b0;
   logic reset = 1'b1;

   frame_sched_if #(.N_OBJ(N_OBJ)) bus ();

   frame_sched #(.N_OBJ(N_OBJ), .FRAME_DIV(FRAME_DIV), .TIMEOUT(TIMEOUT)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int cur      = -1;

   // stimulus per cycle
   logic [XW-1:0]    d_x    [MAXC];
   logic [YW-1:0]    d_y    [MAXC];
   logic [CW-1:0]    d_col  [MAXC];
   logic [N_OBJ-1:0] d_wren [MAXC];
   logic [N_OBJ-1:0] d_done [MAXC];
   // expectations per cycle
   logic [N_OBJ-1:0] e_start [MAXC];
   logic [N_OBJ-1:0] f_set   [MAXC];
   bit               e_busy  [MAXC];
   bit               e_plot  [MAXC];
   bit               o_set   [MAXC];
   logic [7:0]       e_x     [MAXC];
   logic [6:0]       e_y     [MAXC];
   logic [2:0]       e_col   [MAXC];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cur, obs, exp);
      end
   endtask

   // Lays out frames on the timeline. Cycle c has frame counter value c, so
   // ticks fall on c % FRAME_DIV == FRAME_DIV-1. mark_c returns the first
   // WAIT cycle of slot 0 in the first frame whose tick is at or after mark.
   task automatic build(input int ncyc, input int mark, output int mark_c);
      bit         lv [N_OBJ];
      logic [7:0] lx [N_OBJ];
      logic [6:0] ly [N_OBJ];
      int t, tk, d, h, len, c;
      mark_c = -1;
      for (int k = 0; k < MAXC; k++) begin
         d_x[k]     = XW'($urandom);
         d_y[k]     = YW'($urandom);
         d_col[k]   = CW'($urandom);
         d_wren[k]  = N_OBJ'($urandom);
         d_done[k]  = N_OBJ'($urandom);
         e_start[k] = '0;
         f_set[k]   = '0;
         e_busy[k]  = 1'b0;
         e_plot[k]  = 1'b0;
         o_set[k]   = 1'b0;
         e_x[k]     = '0;
         e_y[k]     = '0;
         e_col[k]   = '0;
      end
      for (int i = 0; i < N_OBJ; i++) begin
         lv[i] = 1'b0;
         lx[i] = '0;
         ly[i] = '0;
      end
      tk = FRAME_DIV - 1;
      while (tk < ncyc) begin
         t = tk + 1;
         if (ERASE) begin
            for (int i = 0; i < N_OBJ; i++) begin
               if (lv[i]) begin
                  e_plot[t] = 1'b1;
                  e_x[t]    = lx[i];
                  e_y[t]    = ly[i];
                  e_col[t]  = 3'd0;
               end
               lv[i] = 1'b0;
               t++;
            end
         end
         for (int i = 0; i < N_OBJ; i++) begin
            e_start[t][i] = 1'b1;
            t++;
            case ($urandom_range(0, 9))
               0:       d = 0;
               1:       d = TIMEOUT;
               2:       d = 1;
               default: d = int'($urandom_range(1, 5));
            endcase
            len = (d == 0) ? TIMEOUT : d;
            if (mark_c < 0 && i == 0 && tk >= mark) mark_c = t;
            for (int k = 0; k < len; k++) begin
               c = t + k;
               e_start[c][i] = 1'b1;
               d_done[c][i]  = (d != 0) && (k == len - 1);
               if (d_wren[c][i]) begin
                  e_plot[c] = 1'b1;
                  e_x[c]    = d_x[c][8*i +: 8];
                  e_y[c]    = d_y[c][7*i +: 7];
                  e_col[c]  = d_col[c][3*i +: 3];
                  lv[i]     = 1'b1;
                  lx[i]     = d_x[c][8*i +: 8];
                  ly[i]     = d_y[c][7*i +: 7];
               end
            end
            t += len;
            if (d == 0) begin
               f_set[t-1][i] = 1'b1;
               continue;
            end
            case ($urandom_range(0, 5))
               0:       h = TIMEOUT;
               1:       h = 0;
               default: h = int'($urandom_range(0, 5));
            endcase
            len = (h >= TIMEOUT) ? TIMEOUT : h + 1;
            for (int k = 0; k < len; k++) d_done[t+k][i] = (k < h);
            if (h >= TIMEOUT) f_set[t+len-1][i] = 1'b1;
            t += len;
         end
         for (int k = tk + 1; k < t; k++) begin
            e_busy[k] = 1'b1;
            if (k % FRAME_DIV == FRAME_DIV - 1) o_set[k] = 1'b1;
         end
         tk = (t / FRAME_DIV) * FRAME_DIV + FRAME_DIV - 1;
      end
   endtask

   task automatic run(input int ncyc, input int rst_c);
      logic [N_OBJ-1:0] fault_m;
      logic             ovr_m;
      logic [7:0]       hx;
      logic [6:0]       hy;
      logic [2:0]       hc;
      cur           = -1;
      reset         = 1'b1;
      bus.done      = '0;
      bus.obj_wren  = '0;
      bus.obj_x     = '0;
      bus.obj_y     = '0;
      bus.obj_color = '0;
      @(negedge clk);
      chk("rst_start",   32'(bus.start),     32'd0);
      chk("rst_busy",    32'(bus.busy),      32'd0);
      chk("rst_plot",    32'(bus.vga_plot),  32'd0);
      chk("rst_vga_x",   32'(bus.vga_x),     32'd0);
      chk("rst_vga_y",   32'(bus.vga_y),     32'd0);
      chk("rst_color",   32'(bus.vga_color), 32'd0);
      chk("rst_fault",   32'(bus.fault),     32'd0);
      chk("rst_overrun", 32'(bus.overrun),   32'd0);
      fault_m = '0;
      ovr_m   = 1'b0;
      hx      = '0;
      hy      = '0;
      hc      = '0;
      @(posedge clk);
      #2 reset = 1'b0;
      for (int c = 0; c < ncyc; c++) begin
         cur           = c;
         bus.done      = d_done[c];
         bus.obj_wren  = d_wren[c];
         bus.obj_x     = d_x[c];
         bus.obj_y     = d_y[c];
         bus.obj_color = d_col[c];
         @(negedge clk);
         if (e_plot[c]) begin
            hx = e_x[c];
            hy = e_y[c];
            hc = e_col[c];
         end
         chk("start",   32'(bus.start),     32'(e_start[c]));
         chk("busy",    32'(bus.busy),      32'(e_busy[c]));
         chk("plot",    32'(bus.vga_plot),  32'(e_plot[c]));
         chk("vga_x",   32'(bus.vga_x),     32'(hx));
         chk("vga_y",   32'(bus.vga_y),     32'(hy));
         chk("color",   32'(bus.vga_color), 32'(hc));
         chk("fault",   32'(bus.fault),     32'(fault_m));
         chk("overrun", 32'(bus.overrun),   32'(ovr_m));
         if (c == rst_c) begin
            #2 reset = 1'b1;
            #1;
            chk("async_rst_start", 32'(bus.start),    32'd0);
            chk("async_rst_plot",  32'(bus.vga_plot), 32'd0);
            chk("async_rst_busy",  32'(bus.busy),     32'd0);
            return;
         end
         fault_m = fault_m | f_set[c];
         ovr_m   = ovr_m | o_set[c];
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      int rc;
      // session 1: random frames, then reset during slot 0 WAIT
      build(900, 600, rc);
      run((rc >= 0) ? rc + 1 : 900, rc);
      // session 2: fresh run after the abandoned frame, no erase owed
      build(400, MAXC, rc);
      run(400, -1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/frame_sched.md
# frame_sched

Frame-rate sequencer sitting directly upstream of the per-object updaters (bullets, player) and in front of the VGA framebuffer write port. Once per frame it erases each object's previously drawn pixel, then runs every object slot in turn through the start/done handshake. It forwards each slot's plot requests to the single framebuffer port and records the last drawn position for the next erase. Slot timeouts and frame overruns are flagged.

## Interface
- N_OBJ, 4: number of object slots; slot 0 runs first.
- FRAME_DIV, 833333: clk cycles per frame (50 MHz / 60 Hz).
- TIMEOUT, 64: max cycles to wait on any single done edge per slot.
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- start  out  N_OBJ  per-slot start, one-hot or zero
- done  in  N_OBJ  per-slot done from updaters
- obj_x  in  8*N_OBJ  slot i coordinates in bits [8i+7:8i]
- obj_y  in  7*N_OBJ  slot i in bits [7i+6:7i]
- obj_color  in  3*N_OBJ  slot i in bits [3i+2:3i]
- obj_wren  in  N_OBJ  active-high plot request from slot i
- vga_x  out  8  framebuffer x
- vga_y  out  7  framebuffer y
- vga_color  out  3  framebuffer colour
- vga_plot  out  1  framebuffer write strobe, one pixel per high cycle
- busy  out  1  high whenever state is not IDLE
- fault  out  N_OBJ  sticky, bit i set on slot i timeout
- overrun  out  1  sticky, tick arrived while busy

## Operation
- Frame counter counts 0..FRAME_DIV-1 and wraps; tick is high for the single cycle in which count == FRAME_DIV-1.
- States: IDLE, ERASE, START, WAIT, RELEASE.
- IDLE: on tick go to ERASE with slot index 0. Without tick, stay.
- ERASE: one cycle per slot, index 0..N_OBJ-1. If last_valid[i], drive vga_plot=1, vga_x/y=last_x/y[i], vga_color=0. Clear last_valid[i]. After slot N_OBJ-1, reset the index to 0 and go to START.
- START: drive start[i]=1 for one cycle and load the timeout counter, then go to WAIT.
- WAIT: hold start[i]=1.
  - On each cycle with obj_wren[i]=1, drive vga_plot=1 with obj_x/y/color[i], latch last_x/y[i] and set last_valid[i].
  - When done[i]=1, go to RELEASE.
- RELEASE: start[i]=0; wait for done[i]=0. Then advance the index, or go to IDLE after slot N_OBJ-1.
- obj_wren from non-active slots is ignored.
- Timeout: the counter runs in WAIT and RELEASE and reloads on the WAIT->RELEASE transition. If it reaches TIMEOUT, set fault[i], drop start[i], and advance as if the slot had completed. Plot data from that slot is kept.
- Tick while busy: set overrun and discard the tick. The frame counter keeps running.
- vga_plot=0 in IDLE, START and RELEASE. vga_x/y/color hold their last value when vga_plot=0.
- fault and overrun clear only on reset.

## Timing
- Reset values: all outputs 0, state IDLE, frame counter 0, all last_valid 0, slot index 0.
- Reset asserted mid-frame: start drops asynchronously. The in-flight slot is abandoned and no erase is owed.
- Tick to first ERASE plot: 1 cycle. ERASE phase: exactly N_OBJ cycles.
- START to done sampled: updater-dependent (≥3 cycles for a bullet updater).
- Plot forwarding is combinational from obj_wren in WAIT; the latch of last_x/y occurs on the same edge.
- Per-slot minimum: START(1) + WAIT(≥1) + RELEASE(≥1).
- Simultaneous done[i] and obj_wren[i] in WAIT: the plot is forwarded and latched, and the transition to RELEASE still happens.

## Configuration
- FRAME_SCHED_ERASE_EN defined: ERASE state and last_x/last_y/last_valid registers present; behaviour as above.
- FRAME_SCHED_ERASE_EN undefined: IDLE goes directly to START on tick and no position storage exists. Latency from tick to first start[0] is 1 cycle. Objects are expected to erase themselves.

## Test plan
- N_OBJ=2, FRAME_DIV=16, TIMEOUT=8, both slots model bullets plotting (10,20) and (30,40): first tick gives no erase plots, start[0] then start[1], vga_plot pulses with those coordinates, busy returns to 0.
- Second tick, ERASE_EN defined: two colour-0 plots at (10,20) then (30,40) in consecutive cycles before start[0] rises.
- Slot 1 never asserts done: fault=2'b10 after 8 WAIT cycles, start[1] drops, and the sequencer returns to IDLE.
- Slot 0 holds done high 5 cycles after start drops: the sequencer stays in RELEASE, and start[1] rises only after done[0] falls.
- FRAME_DIV=16 with a slot taking 20 cycles: overrun=1, the tick is skipped, and the next frame begins at the following tick.
- Assert reset during WAIT of slot 0: start, vga_plot and busy go to 0 immediately. After release, the next tick gives no erase plots.
